// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state, state_next;
    logic [31:0] cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, a_div, b_div, q_raw, r_raw;
    logic [31:0]        res_hi, res_lo;
    logic [31:0]        cnt_load;
    logic               is_signed_div, div_zero, is_md;

    assign is_md         = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                           (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
    assign is_signed_div = (MDOp == OP_DIV);
    assign div_zero      = (B == 32'd0);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case
    assign a_mag = A[31] ? (~A + 32'd1) : A;
    assign b_mag = B[31] ? (~B + 32'd1) : B;
    assign a_div = is_signed_div ? a_mag : A;
    assign b_div = is_signed_div ? b_mag : B;
    assign q_raw = div_zero ? 32'd0 : (a_div / b_div);
    assign r_raw = div_zero ? 32'd0 : (a_div % b_div);

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        cnt_load = 32'(MULT_CYCLES);
        case (MDOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                cnt_load = 32'(DIV_CYCLES);
                res_lo   = (A[31] ^ B[31]) ? (~q_raw + 32'd1) : q_raw;
                res_hi   = A[31] ? (~r_raw + 32'd1) : r_raw;
            end
            OP_DIVU: begin
                cnt_load = 32'(DIV_CYCLES);
                res_lo   = q_raw;
                res_hi   = r_raw;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start && is_md) state_next = BUSY;
            BUSY: if (cnt == 32'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (is_md) begin
                            cnt     <= cnt_load;
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= !((MDOp == OP_DIV || MDOp == OP_DIVU) && div_zero);
                        end else if (MDOp == OP_MTHI) begin
                            HI <= A;
                        end else if (MDOp == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        pend_wr <= 1'b0;
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state == BUSY);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi, m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; samples and drives happen 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns in cycle n+1 with the op committed
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, " busy c0"}, 32'(Busy), 32'd0);
        Start = 1'b1; MDOp = op; A = a; B = b;
        step();
        Start = 1'b0; A = 32'h0; B = 32'h0;
        for (int i = 1; i <= n; i++) begin
            check($sformatf("%s busy c%0d", tag, i), 32'(Busy), 32'd1);
            check($sformatf("%s hi hold c%0d", tag, i), HI, m_hi);
            check($sformatf("%s lo hold c%0d", tag, i), LO, m_lo);
            step();
        end
        check({tag, " busy end"}, 32'(Busy), 32'd0);
        check({tag, " hi"}, HI, exp_hi);
        check({tag, " lo"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic move(input string tag, input logic [2:0] op, input logic [31:0] a);
        Start = 1'b1; MDOp = op; A = a;
        step();
        Start = 1'b0; A = 32'h0;
        if (op == 3'd4) m_hi = a; else m_lo = a;
        check({tag, " busy"}, 32'(Busy), 32'd0);
        check({tag, " hi"}, HI, m_hi);
        check({tag, " lo"}, LO, m_lo);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'h0; B = 32'h0;
        m_hi = 32'h0; m_lo = 32'h0;
        #2;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset hi", HI, 32'h0);
        check("reset lo", LO, 32'h0);
        // Start during reset must be ignored
        Start = 1'b1; MDOp = 3'd4; A = 32'hAAAA_AAAA;
        step();
        Start = 1'b0; A = 32'h0;
        check("start in reset hi", HI, 32'h0);
        check("start in reset busy", 32'(Busy), 32'd0);
        reset = 1'b0;
        step();

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu b2b", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("mult pos", 3'd0, 32'd7, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Divide by zero leaves HI/LO untouched after the full busy phase
        move("mthi 11", 3'd4, 32'h11);
        move("mtlo 22", 3'd5, 32'h22);
        run_op("div0", 3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("divu0", 3'd3, 32'd9, 32'd0, 10, 32'h11, 32'h22);

        // Reserved opcode does nothing
        Start = 1'b1; MDOp = 3'd6; A = 32'h1234;
        step();
        Start = 1'b0;
        check("reserved busy", 32'(Busy), 32'd0);
        check("reserved hi", HI, 32'h11);
        check("reserved lo", LO, 32'h22);

        // Start while busy is ignored
        check("swb busy c0", 32'(Busy), 32'd0);
        Start = 1'b1; MDOp = 3'd0; A = 32'd2; B = 32'd3;
        step();
        Start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                Start = 1'b1; MDOp = 3'd5; A = 32'hDEAD;
            end else begin
                Start = 1'b0;
            end
            check($sformatf("swb busy c%0d", c), 32'(Busy), 32'd1);
            check($sformatf("swb lo c%0d", c), LO, 32'h22);
            step();
        end
        Start = 1'b0;
        check("swb busy c6", 32'(Busy), 32'd0);
        check("swb hi c6", HI, 32'h0);
        check("swb lo c6", LO, 32'd6);
        m_hi = 32'h0; m_lo = 32'd6;

        // Reset mid-operation clears everything asynchronously and discards the pending result
        move("mthi 55", 3'd4, 32'h55);
        move("mtlo 55", 3'd5, 32'h55);
        Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0;
        step();
        step();
        check("rst pre busy", 32'(Busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst async busy", 32'(Busy), 32'd0);
        check("rst async hi", HI, 32'h0);
        check("rst async lo", LO, 32'h0);
        step();
        reset = 1'b0;
        for (int c = 4; c <= 14; c++) begin
            check($sformatf("post rst busy c%0d", c), 32'(Busy), 32'd0);
            check($sformatf("post rst hi c%0d", c), HI, 32'h0);
            check($sformatf("post rst lo c%0d", c), LO, 32'h0);
            step();
        end
        m_hi = 32'h0; m_lo = 32'h0;

        run_op("mult after rst", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage, directly upstream of the memory stage. It executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO registers. HI/LO feed the EX result mux for mfhi/mflo, which travels on to the memory stage as the EX result. `Busy` drives the hazard unit, which stalls any HI/LO-class instruction in decode while the unit is occupied.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu; legal range ≥1.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle qualifier: the instruction in EX is an MD operation (already stall/flush-qualified upstream).
- `MDOp`  in  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved.
- `A`  in  32  rs operand, forwarded value.
- `B`  in  32  rt operand, forwarded value.
- `Busy`  out  1  an operation is in flight.
- `HI`  out  32  current HI register, a direct register output.
- `LO`  out  32  current LO register, a direct register output.

## Operation
- Reset values: `HI`=0, `LO`=0, `Busy`=0. The internal counter and pending result are cleared.
- Idle with `Start`=1 accepts an operation at the rising edge:
  - mult/multu/div/divu: `A`, `B` and `MDOp` are captured, or the result is computed and held pending. The counter loads `MULT_CYCLES` or `DIV_CYCLES` and the unit enters BUSY.
  - mthi/mtlo: `HI`←`A` or `LO`←`A` at that edge. No BUSY phase.
  - Reserved codes: no effect.
- State machine:
  - IDLE → BUSY on an accepted mult/multu/div/divu.
  - BUSY: the counter decrements each edge. On the edge where it reaches 0, pending HI/LO are committed and the unit returns to IDLE.
- `Start` while `Busy`=1 is ignored entirely, including mthi/mtlo. HI/LO and the counter are not disturbed. The hazard unit is responsible for never issuing this.
- Arithmetic:
  - mult: signed 32×32→64, `HI`=bits[63:32], `LO`=bits[31:0].
  - multu: unsigned 32×32→64, same split.
  - div: `LO`=quotient truncated toward zero; `HI`=remainder with the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF: `LO`=0x80000000, `HI`=0.
  - divu: unsigned quotient in `LO`, remainder in `HI`.
  - Divide by zero (div or divu, `B`=0): the full `DIV_CYCLES` Busy phase still occurs, and `HI`/`LO` are left unchanged at commit.
- HI/LO change only at mthi/mtlo acceptance, at commit, or at reset.

## Timing
- Let cycle 0 be the cycle in which `Start`=1 with a mult-class op is sampled.
- `Busy` is high in cycles 1..N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
- The new `HI`/`LO` are visible from cycle N+1, in the same cycle `Busy` falls.
- `Busy` is registered and never high in cycle 0. The hazard unit must therefore treat `Start | Busy` as occupancy.
- Back-to-back ops: a new `Start` in cycle N+1 is accepted. Its Busy phase covers N+2..2N+1, so there are no Busy gaps other than the acceptance cycle.
- mthi/mtlo accepted in cycle k: the new value is visible on `HI`/`LO` from cycle k+1.
- `reset` asserted mid-operation: `Busy`, `HI` and `LO` go to 0 asynchronously without waiting for an edge. The pending result is discarded and never committed after reset is released.
- `Start` is ignored in any cycle where `reset`=1.

## Test plan
- mult, `A`=0xFFFFFFFE, `B`=3, N=5 → `Busy`=1 in cycles 1–5; cycle 6 `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA; `HI`/`LO` unchanged in cycles 1–5.
- multu, `A`=`B`=0xFFFFFFFF → `HI`=0xFFFFFFFE, `LO`=0x00000001 after 5 Busy cycles.
- div, `A`=0xFFFFFFF9, `B`=2 → `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. divu with the same operands → `LO`=0x7FFFFFFC, `HI`=0x00000001. Each shows 10 Busy cycles.
- Divide by zero:
  - Stimulus: mthi `A`=0x11, mtlo `A`=0x22, then div `A`=5, `B`=0.
  - `HI`=0x11 and `LO`=0x22 are visible the cycle after each move.
  - `Busy` is high for 10 cycles, then `HI`=0x11, `LO`=0x22 unchanged.
- Start while busy: mult `A`=2, `B`=3 at cycle 0, then `Start` with mtlo `A`=0xDEAD at cycle 2 → `LO` never equals 0xDEAD; cycle 6 `HI`=0, `LO`=6.
- Reset mid-operation: div `A`=100, `B`=7 with `HI`=`LO`=0x55 preset; assert `reset` at cycle 3 → `Busy`, `HI`, `LO` are 0 immediately. After release they remain 0 and `Busy` stays 0 past cycle 11.
